// File: rtl/ecall_pkg.sv
// ecall_pkg: syscall numbers, FSM state encoding and ASCII bases for the ecall unit
package ecall_pkg;
    localparam int SYS_PRINT_HEX = 1;
    localparam int SYS_EXIT      = 10;
    localparam int SYS_PUTC      = 11;
    localparam int SYS_EXIT_CODE = 93;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_A0    = 3'd1;
    localparam logic [2:0] ST_DISPATCH = 3'd2;
    localparam logic [2:0] ST_TX_CHAR  = 3'd3;
    localparam logic [2:0] ST_TX_HEX   = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_HALT     = 3'd6;

    localparam logic [7:0] ASCII_DIGIT = 8'h30;
    localparam logic [7:0] ASCII_ALPHA = 8'h61;
endpackage

// File: rtl/ecall_unit_hex.sv
// hex_nibble_to_ascii: maps a 4-bit value to its lowercase ASCII hex digit
module hex_nibble_to_ascii
    import ecall_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);
    assign ascii = nib < 4'd10 ? ASCII_DIGIT + {4'b0, nib} : ASCII_ALPHA + {4'b0, nib} - 8'd10;
endmodule

// File: rtl/ecall_unit.sv
// ecall_unit: stalls the core and services putc / print-hex / exit environment calls
module ecall_unit
    import ecall_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int A7_IDX = 17,
    parameter int A0_IDX = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ecall,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            stall,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            done,
    output logic            err,
    output logic            halt,
    output logic [7:0]      exit_code
);
    logic [2:0]      state;
    logic [XLEN-1:0] a7_q;
    logic [XLEN-1:0] a0_q;
    logic [2:0]      nib_cnt;
    logic [7:0]      hex_ascii;
    logic            known;

    hex_nibble_to_ascii u_hex (
        .nib   (a0_q[{nib_cnt, 2'b00} +: 4]),
        .ascii (hex_ascii)
    );

    // Outputs are pure decodes of state so they react in the same cycle as the state
    always_comb begin
        known     = a7_q == XLEN'(SYS_PUTC) || a7_q == XLEN'(SYS_PRINT_HEX)
                 || a7_q == XLEN'(SYS_EXIT) || a7_q == XLEN'(SYS_EXIT_CODE);
        rf_raddr  = state == ST_RD_A0 ? 5'(A0_IDX) : 5'(A7_IDX);
        stall     = (ecall && state == ST_IDLE) || (state != ST_IDLE && state != ST_DONE);
        tx_valid  = state == ST_TX_CHAR || state == ST_TX_HEX;
        tx_data   = state == ST_TX_CHAR ? a0_q[7:0] : state == ST_TX_HEX ? hex_ascii : 8'h00;
        done      = state == ST_DONE;
        err       = state == ST_DISPATCH && !known;
        halt      = state == ST_HALT;
    end

    // Call sequencer: fetch a7 then a0, dispatch, stream bytes, then retire or halt
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a7_q      <= '0;
            a0_q      <= '0;
            nib_cnt   <= '0;
            exit_code <= '0;
        end else begin
            case (state)
                ST_IDLE: if (ecall) begin
                    a7_q  <= rf_rdata;
                    state <= ST_RD_A0;
                end
                ST_RD_A0: begin
                    a0_q  <= rf_rdata;
                    state <= ST_DISPATCH;
                end
                ST_DISPATCH: begin
                    if (a7_q == XLEN'(SYS_PUTC)) begin
                        state <= ST_TX_CHAR;
                    end else if (a7_q == XLEN'(SYS_PRINT_HEX)) begin
                        nib_cnt <= 3'd7;
                        state   <= ST_TX_HEX;
                    end else if (a7_q == XLEN'(SYS_EXIT)) begin
                        exit_code <= 8'h00;
                        state     <= ST_HALT;
                    end else if (a7_q == XLEN'(SYS_EXIT_CODE)) begin
                        exit_code <= a0_q[7:0];
                        state     <= ST_HALT;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_TX_CHAR: if (tx_ready) state <= ST_DONE;
                ST_TX_HEX: if (tx_ready) begin
                    if (nib_cnt == 3'd0) state <= ST_DONE;
                    else nib_cnt <= nib_cnt - 3'd1;
                end
                ST_DONE: state <= ST_IDLE;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/ecall_unit.md
# ecall_unit

Services `ecall` instructions raised by the control unit's decode of opcode `7'b1110011`. While an ecall is being handled, the block holds the core stalled and reads the syscall number (a7/x17) and argument (a0/x10) from the register file. It then executes one of a small set of environment calls: print a character, print a word as hex, or exit. Character output leaves through a valid/ready byte stream; exit latches a halt and an exit code.

## Interface
Parameters:
- `XLEN`, 32, register/data width.
- `A7_IDX`, 17, register index of the syscall number.
- `A0_IDX`, 10, register index of the argument.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ecall`  in  1  from control unit; high while the ecall instruction is in decode.
- `rf_raddr`  out  5  register-file read address (asynchronous read port).
- `rf_rdata`  in  XLEN  register-file read data, same cycle as `rf_raddr`.
- `stall`  out  1  freezes PC/decode while high.
- `tx_valid`  out  1  output byte valid.
- `tx_data`  out  8  output byte.
- `tx_ready`  in  1  sink accepts byte.
- `done`  out  1  one-cycle pulse when an ecall completes (not on exit).
- `err`  out  1  one-cycle pulse on unsupported syscall number.
- `halt`  out  1  sticky; set by exit calls.
- `exit_code`  out  8  valid while `halt`=1.

## Operation
- States: IDLE, RD_A0, DISPATCH, TX_CHAR, TX_HEX, DONE, HALT.
- **IDLE**
  - `rf_raddr`=A7_IDX.
  - On `ecall`=1: capture `rf_rdata` into `a7_q` and go to RD_A0.
- **RD_A0**
  - `rf_raddr`=A0_IDX.
  - Capture `rf_rdata` into `a0_q`, then go to DISPATCH.
- **DISPATCH** decodes `a7_q`:
  - 11: go to TX_CHAR.
  - 1: go to TX_HEX with `nib_cnt`=7.
  - 10: `exit_code`=0, go to HALT.
  - 93: `exit_code`=`a0_q[7:0]`, go to HALT.
  - Any other value: pulse `err` and go to DONE.
- **TX_CHAR**
  - `tx_valid`=1, `tx_data`=`a0_q[7:0]`.
  - On `tx_ready`: go to DONE.
- **TX_HEX**
  - `tx_valid`=1, `tx_data`=ASCII of nibble `a0_q[4*nib_cnt+3 : 4*nib_cnt]`, MSB nibble first.
  - Nibble 0–9 maps to 0x30+n; 10–15 maps to 0x61+(n−10), lowercase.
  - On handshake: if `nib_cnt`=0 go to DONE, else decrement `nib_cnt`.
- **DONE**
  - `done`=1 and `stall`=0, so the pipeline retires the ecall this cycle.
  - Next state is IDLE.
- **HALT**
  - Terminal; `halt`=1, `stall`=1.
  - Ignores `ecall` and `tx_ready`; only `rst` leaves.
- `stall` = (`ecall` & state==IDLE) | (state ∉ {IDLE, DONE}). This is combinational, so the core freezes in the same cycle the ecall is decoded.
- `tx_data` is stable whenever `tx_valid`=1 and holds until the handshake completes. `tx_valid` never drops without a handshake, except on `rst`.

## Timing
- Reset values:
  - state=IDLE.
  - `stall`=0 (absent `ecall`), `tx_valid`=0, `tx_data`=0.
  - `done`=0, `err`=0, `halt`=0, `exit_code`=0.
  - `a7_q`=`a0_q`=0, `nib_cnt`=0.
- Cycle C0: `ecall` seen in IDLE, a7 captured. C1: a0 captured. C2: DISPATCH.
- Print char with `tx_ready` tied high:
  - `tx_valid` in C3, DONE in C4.
  - `stall` is high C0–C3 and low in C4.
- Print hex with `tx_ready` high: 8 consecutive bytes in C3–C10, DONE in C11.
- Each cycle `tx_ready`=0 adds one cycle of latency.
- Unsupported call: `err` pulses in C2, DONE in C3.
- Exit: HALT in C3; `halt` and `exit_code` visible from C3.
- `ecall` is sampled only in IDLE; `ecall` asserted in DONE is ignored.
- `rst` mid-operation:
  - All state returns to IDLE at the next edge.
  - A pending `tx_valid` is dropped and the partial hex string is abandoned.
  - `halt` clears.
- Simultaneous `rst` and `ecall`: `rst` wins.

## Structure
- Package `ecall_pkg`:
  - Syscall constants: SYS_PRINT_HEX=1, SYS_EXIT=10, SYS_PUTC=11, SYS_EXIT_CODE=93.
  - State enum.
  - ASCII base constants 0x30 and 0x61.
- Sub-module `hex_nibble_to_ascii`: combinational 4→8-bit conversion, used by TX_HEX.
- One FSM plus datapath registers (`a7_q`, `a0_q`, `nib_cnt`, `exit_code`) in `ecall_unit`.

## Test plan
- a7=11, a0=0x41, `tx_ready`=1: single byte 0x41 in C3, `done` pulse in C4, `stall` high for exactly 4 cycles.
- a7=1, a0=0xDEADBEEF, `tx_ready` toggling 1/0:
  - Bytes 0x64,0x65,0x61,0x64,0x62,0x65,0x65,0x66 ("deadbeef"), in order.
  - `tx_data` stable while stalled by `tx_ready`=0.
  - One `done` pulse.
- a7=93, a0=0x103: `halt`=1, `exit_code`=0x03 from C3. A further `ecall` and 20 idle cycles leave `halt`=1 and `stall`=1, with no `done`.
- a7=5: `err` pulse in C2, `done` in C3, `tx_valid` never asserted.
- a7=1, a0=0x12345678, `rst` after the 3rd handshake: next cycle `tx_valid`=0 and state=IDLE. A following a7=11 ecall works normally.
- Back-to-back ecalls with the second asserted in DONE: the second is ignored. Re-asserting `ecall` one cycle later (in IDLE) starts a new call.
